// File: rtl/avs_pkg.sv
// AVSBus slave emulator shared types: frame layouts, command/type/ack encodings and the CRC-3
// used on both command and response frames.
package avs_pkg;

  localparam int unsigned AVS_FRAME_LEN = 32;
  localparam logic [3:0]  SEL_BCAST     = 4'hF;

  typedef enum logic [1:0] {
    CmdCommit = 2'b00,
    CmdHold   = 2'b01,
    CmdRsvd   = 2'b10,
    CmdRead   = 2'b11
  } avs_cmd_e;

  typedef enum logic [3:0] {
    TypeVout   = 4'h0,
    TypeVrst   = 4'h4,
    TypeStatus = 4'hE
  } avs_type_e;

  typedef enum logic [1:0] {
    AckOk     = 2'b00,
    AckBadCrc = 2'b10,
    AckRej    = 2'b11
  } avs_ack_e;

  typedef struct packed {
    logic [1:0]  start;
    avs_cmd_e    cmd;
    logic        group;
    avs_type_e   typ;
    logic [3:0]  sel;
    logic [15:0] data;
    logic [2:0]  crc;
  } avs_cmd_frame_t;

  typedef struct packed {
    avs_ack_e    ack;
    logic        rsvd;
    logic [4:0]  status;
    logic [15:0] data;
    logic [4:0]  ones;
    logic [2:0]  crc;
  } avs_resp_frame_t;

  // x^3 + x + 1, init 0, MSB first
  function automatic logic [2:0] crc3(input logic [28:0] bits);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int i = 28; i >= 0; i--) begin
      fb = c[2] ^ bits[i];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

endpackage

// File: rtl/avs_rail_ramp.sv
// One emulated rail: committed target, pending hold value and a slew-limited output voltage.
module avs_rail_ramp #(
  parameter logic [15:0] VOUT_RESET = 16'd800,
  parameter logic [15:0] SLEW_STEP  = 16'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        commit,
  input  logic        commit_we,
  input  logic        hold_we,
  input  logic [15:0] wr_val,
  output logic [15:0] vout,
  output logic        vdone
);

  logic [15:0] target_q, hold_q, vout_q, vout_nxt;
  logic        hold_vld_q;

  always_comb begin
    vout_nxt = vout_q;
    if (target_q > vout_q) begin
      vout_nxt = (target_q - vout_q <= SLEW_STEP) ? target_q : vout_q + SLEW_STEP;
    end else if (target_q < vout_q) begin
      vout_nxt = (vout_q - target_q <= SLEW_STEP) ? target_q : vout_q - SLEW_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q   <= VOUT_RESET;
      hold_q     <= VOUT_RESET;
      hold_vld_q <= 1'b0;
      vout_q     <= VOUT_RESET;
    end else begin
      // A direct write in the committing frame overrides this rail's held value
      if (commit) begin
        hold_vld_q <= 1'b0;
        if (commit_we) begin
          target_q <= wr_val;
        end else if (hold_vld_q) begin
          target_q <= hold_q;
        end
      end else if (hold_we) begin
        hold_q     <= wr_val;
        hold_vld_q <= 1'b1;
      end
      if (tick) begin
        vout_q <= vout_nxt;
      end
    end
  end

  assign vout  = vout_q;
  assign vdone = (vout_q == target_q);

endmodule

// File: rtl/avs_slave_emu.sv
// Multi-rail AVSBus slave emulator: oversamples the bus, decodes command frames, drives the
// response frame and owns the per-rail ramp instances.
module avs_slave_emu
  import avs_pkg::*;
#(
  parameter int unsigned NUM_RAILS   = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] VOUT_RESET  = 16'd800,
  parameter logic [15:0] SLEW_STEP   = 16'd5,
  parameter int unsigned RAMP_DIV    = 100,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    avs_clk_i,
  input  logic                    avs_mdata_i,
  output logic                    avs_sdata_o,
  output logic [NUM_RAILS*16-1:0] vout_o,
  output logic [NUM_RAILS-1:0]    vdone_o,
  output logic                    frame_err_o
);

  localparam int unsigned DivW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [5:0]  LastBit = 6'(AVS_FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StResp, StErrWait} state_e;

  state_e                     state_q;
  logic [SYNC_STAGES-1:0]     aclk_sync_q, mdat_sync_q;
  logic                       aclk_prev_q, aclk_s, mdata_s, aclk_rise, aclk_fall, timeout;
  logic [AVS_FRAME_LEN-2:0]   shift_q;
  logic [AVS_FRAME_LEN-1:0]   resp_sr_q;
  logic [5:0]                 bit_cnt_q;
  logic [ToW-1:0]             to_cnt_q;
  logic [DivW-1:0]            div_q;
  logic                       tick, sdata_q, frame_err_q, commit_q, alert_clr_q, alert_q;
  logic [NUM_RAILS-1:0]       commit_we_q, hold_we_q, rail_hit, vdone, vdone_prev_q;
  logic [15:0]                wr_val_q, wr_val, rd_vout;
  logic [15:0]                vout_arr [NUM_RAILS];

  avs_cmd_frame_t  cf;
  avs_resp_frame_t rsp;
  avs_ack_e        ack;
  logic            crc_ok, bcast, sel_ok, is_write, is_read, supported;
  logic [4:0]      status;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aclk_sync_q <= '1;
      mdat_sync_q <= '1;
      aclk_prev_q <= 1'b1;
    end else begin
      aclk_sync_q[0] <= avs_clk_i;
      mdat_sync_q[0] <= avs_mdata_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        aclk_sync_q[i] <= aclk_sync_q[i-1];
        mdat_sync_q[i] <= mdat_sync_q[i-1];
      end
      aclk_prev_q <= aclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign aclk_s    = aclk_sync_q[SYNC_STAGES-1];
  assign mdata_s   = mdat_sync_q[SYNC_STAGES-1];
  assign aclk_rise = aclk_s & ~aclk_prev_q;
  assign aclk_fall = ~aclk_s & aclk_prev_q;
  assign timeout   = (to_cnt_q == ToW'(TIMEOUT_CYC - 1)) && !(aclk_rise || aclk_fall);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
    end
  end
  assign tick = (div_q == DivW'(RAMP_DIV - 1));

  // Decode of the frame as it will stand once the current sample is shifted in
  always_comb begin
    cf        = avs_cmd_frame_t'({shift_q, mdata_s});
    crc_ok    = (crc3(cf[31:3]) == cf.crc);
    bcast     = (cf.sel == SEL_BCAST);
    sel_ok    = bcast || (32'(cf.sel) < NUM_RAILS);
    is_write  = (cf.cmd == CmdCommit) || (cf.cmd == CmdHold);
    is_read   = (cf.cmd == CmdRead);
    supported = !cf.group && sel_ok &&
                ((is_write && (cf.typ == TypeVout || cf.typ == TypeVrst)) ||
                 (is_read && !bcast && (cf.typ == TypeVout || cf.typ == TypeStatus)));
    ack       = !crc_ok ? AckBadCrc : (supported ? AckOk : AckRej);
    status    = {&vdone, alert_q, 3'b000};
    wr_val    = (cf.typ == TypeVrst) ? VOUT_RESET : cf.data;
    rd_vout   = '0;
    rail_hit  = '0;
    for (int r = 0; r < NUM_RAILS; r++) begin
      rail_hit[r] = bcast || (cf.sel == 4'(r));
      if (cf.sel == 4'(r)) begin
        rd_vout = vout_arr[r];
      end
    end
    rsp.ack    = ack;
    rsp.rsvd   = 1'b0;
    rsp.status = status;
    rsp.data   = '0;
    if (ack == AckOk && is_read) begin
      rsp.data = (cf.typ == TypeStatus) ? {11'h0, status} : rd_vout;
    end
    rsp.ones = 5'h1F;
    rsp.crc  = crc3({rsp.ack, rsp.rsvd, rsp.status, rsp.data, rsp.ones});
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      resp_sr_q   <= '0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      sdata_q     <= 1'b1;
      frame_err_q <= 1'b0;
      commit_q    <= 1'b0;
      commit_we_q <= '0;
      hold_we_q   <= '0;
      wr_val_q    <= '0;
      alert_clr_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      commit_q    <= 1'b0;
      commit_we_q <= '0;
      hold_we_q   <= '0;
      alert_clr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          sdata_q  <= ~alert_q;
          to_cnt_q <= '0;
          if (aclk_rise && !mdata_s) begin
            state_q   <= StCmd;
            shift_q   <= '0;
            bit_cnt_q <= 6'd1;
            sdata_q   <= 1'b1;
          end
        end
        StCmd: begin
          to_cnt_q <= (aclk_rise || aclk_fall) ? '0 : to_cnt_q + 1'b1;
          if (timeout) begin
            frame_err_q <= 1'b1;
            state_q     <= StIdle;
            sdata_q     <= 1'b1;
          end else if (aclk_rise) begin
            shift_q   <= {shift_q[AVS_FRAME_LEN-3:0], mdata_s};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 6'd1 && !mdata_s) begin
              frame_err_q <= 1'b1;
              state_q     <= StErrWait;
            end else if (bit_cnt_q == LastBit) begin
              state_q     <= StResp;
              bit_cnt_q   <= '0;
              resp_sr_q   <= rsp;
              frame_err_q <= (ack == AckBadCrc);
              wr_val_q    <= wr_val;
              if (ack == AckOk) begin
                if (cf.cmd == CmdCommit) begin
                  commit_q    <= 1'b1;
                  commit_we_q <= rail_hit;
                end else if (cf.cmd == CmdHold) begin
                  hold_we_q <= rail_hit;
                end else if (cf.typ == TypeStatus) begin
                  alert_clr_q <= 1'b1;
                end
              end
            end
          end
        end
        StResp: begin
          to_cnt_q <= (aclk_rise || aclk_fall) ? '0 : to_cnt_q + 1'b1;
          if (timeout) begin
            frame_err_q <= 1'b1;
            state_q     <= StIdle;
            sdata_q     <= 1'b1;
          end else begin
            if (aclk_fall) begin
              sdata_q   <= resp_sr_q[AVS_FRAME_LEN-1];
              resp_sr_q <= {resp_sr_q[AVS_FRAME_LEN-2:0], 1'b0};
            end
            if (aclk_rise) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == LastBit) begin
                state_q <= StIdle;
              end
            end
          end
        end
        StErrWait: begin
          sdata_q  <= 1'b1;
          to_cnt_q <= '0;
          if (mdata_s) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Alert latches any rail arriving at target; a status read clears it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vdone_prev_q <= '1;
      alert_q      <= 1'b0;
    end else begin
      vdone_prev_q <= vdone;
      alert_q      <= (alert_q & ~alert_clr_q) | (|(vdone & ~vdone_prev_q));
    end
  end

  for (genvar r = 0; r < NUM_RAILS; r++) begin : g_rail
    avs_rail_ramp #(
      .VOUT_RESET(VOUT_RESET),
      .SLEW_STEP (SLEW_STEP)
    ) u_rail (
      .clk      (clk_i),
      .rst      (rst_i),
      .tick     (tick),
      .commit   (commit_q),
      .commit_we(commit_we_q[r]),
      .hold_we  (hold_we_q[r]),
      .wr_val   (wr_val_q),
      .vout     (vout_arr[r]),
      .vdone    (vdone[r])
    );
    assign vout_o[r*16 +: 16] = vout_arr[r];
  end

  assign vdone_o     = vdone;
  assign avs_sdata_o = sdata_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_avs_slave_emu.sv
// Directed bench for avs_slave_emu: bit-banged AVSBus master, expected frames built from field values.
module tb_avs_slave_emu;

  localparam int HALF = 6;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        avs_clk_i = 1'b1;
  logic        avs_mdata_i = 1'b1;
  logic        avs_sdata_o;
  logic [31:0] vout_o;
  logic [1:0]  vdone_o;
  logic        frame_err_o;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (frame_err_o === 1'b1) err_cnt <= err_cnt + 1;
  end

  avs_slave_emu #(
    .NUM_RAILS(2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .avs_clk_i  (avs_clk_i),
    .avs_mdata_i(avs_mdata_i),
    .avs_sdata_o(avs_sdata_o),
    .vout_o     (vout_o),
    .vdone_o    (vdone_o),
    .frame_err_o(frame_err_o)
  );

  // Remainder of d(x)*x^3 divided by x^3+x+1
  function automatic logic [2:0] crc_div(input logic [28:0] d);
    logic [31:0] r;
    r = {d, 3'b000};
    for (int i = 31; i >= 3; i--) begin
      if (r[i]) r[i-:4] = r[i-:4] ^ 4'b1011;
    end
    return r[2:0];
  endfunction

  function automatic logic [31:0] mk_frame(input logic [1:0] cmd, input logic grp,
                                           input logic [3:0] typ, input logic [3:0] sel,
                                           input logic [15:0] data);
    logic [28:0] h;
    h = {2'b01, cmd, grp, typ, sel, data};
    return {h, crc_div(h)};
  endfunction

  function automatic logic [31:0] mk_resp(input logic [1:0] ack, input logic [4:0] st,
                                          input logic [15:0] data);
    logic [28:0] h;
    h = {ack, 1'b0, st, data, 5'h1F};
    return {h, crc_div(h)};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic xfer(input logic [31:0] frm, input int rst_at, output logic [31:0] rsp);
    rsp = '0;
    for (int i = 0; i < 64; i++) begin
      avs_clk_i   = 1'b0;
      avs_mdata_i = (i < 32) ? frm[31-i] : 1'b1;
      wait_clk(HALF);
      if (i >= 32) rsp[63-i] = avs_sdata_o;
      if (i == rst_at) begin
        rst_i = 1'b1;
        wait_clk(2);
        rst_i = 1'b0;
      end
      avs_clk_i = 1'b1;
      wait_clk(HALF);
    end
    avs_mdata_i = 1'b1;
  endtask

  task automatic partial(input logic [31:0] frm, input int n);
    for (int i = 0; i < n; i++) begin
      avs_clk_i   = 1'b0;
      avs_mdata_i = frm[31-i];
      wait_clk(HALF);
      avs_clk_i = 1'b1;
      wait_clk(HALF);
    end
    avs_mdata_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    wait_clk(5);
    rst_i = 1'b0;
    wait_clk(20);
    total++; if (avs_sdata_o !== 1'b1) begin bad++; $display("FAIL rst_sdata got=%b exp=1", avs_sdata_o); end
    total++; if (vout_o !== {16'd800, 16'd800}) begin bad++; $display("FAIL rst_vout got=%h exp=%h", vout_o, {16'd800, 16'd800}); end
    total++; if (vdone_o !== 2'b11) begin bad++; $display("FAIL rst_vdone got=%b exp=11", vdone_o); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL rst_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_write_commit();
    logic [31:0] rsp, exp;
    xfer(mk_frame(2'b00, 1'b0, 4'h0, 4'h0, 16'd900), -1, rsp);
    exp = mk_resp(2'b00, 5'b10000, 16'h0);
    total++; if (rsp !== exp) begin bad++; $display("FAIL wc_resp got=%h exp=%h", rsp, exp); end
    wait_clk(2);
    total++; if (vdone_o !== 2'b10) begin bad++; $display("FAIL wc_ramping got=%b exp=10", vdone_o); end
    total++; if (avs_sdata_o !== 1'b1) begin bad++; $display("FAIL wc_idle_noalert got=%b exp=1", avs_sdata_o); end
    wait_clk(2000);
    total++; if (vout_o[15:0] !== 16'd900) begin bad++; $display("FAIL wc_vout0 got=%0d exp=900", vout_o[15:0]); end
    total++; if (vdone_o !== 2'b11) begin bad++; $display("FAIL wc_vdone got=%b exp=11", vdone_o); end
    total++; if (avs_sdata_o !== 1'b0) begin bad++; $display("FAIL wc_alert_sdata got=%b exp=0", avs_sdata_o); end
  endtask

  task automatic test_hold_read();
    logic [31:0] rsp, exp;
    xfer(mk_frame(2'b01, 1'b0, 4'h0, 4'h1, 16'd950), -1, rsp);
    exp = mk_resp(2'b00, 5'b11000, 16'h0);
    total++; if (rsp !== exp) begin bad++; $display("FAIL hold_resp got=%h exp=%h", rsp, exp); end
    xfer(mk_frame(2'b11, 1'b0, 4'h0, 4'h1, 16'h0), -1, rsp);
    exp = mk_resp(2'b00, 5'b11000, 16'd800);
    total++; if (rsp !== exp) begin bad++; $display("FAIL read1_resp got=%h exp=%h", rsp, exp); end
    xfer(mk_frame(2'b00, 1'b0, 4'h0, 4'h0, 16'd700), -1, rsp);
    exp = mk_resp(2'b00, 5'b11000, 16'h0);
    total++; if (rsp !== exp) begin bad++; $display("FAIL commit700_resp got=%h exp=%h", rsp, exp); end
    wait_clk(2);
    total++; if (vdone_o !== 2'b00) begin bad++; $display("FAIL both_ramping got=%b exp=00", vdone_o); end
    wait_clk(4000);
    total++; if (vout_o !== {16'd950, 16'd700}) begin bad++; $display("FAIL hold_vout got=%h exp=%h", vout_o, {16'd950, 16'd700}); end
    total++; if (vdone_o !== 2'b11) begin bad++; $display("FAIL hold_vdone got=%b exp=11", vdone_o); end
  endtask

  task automatic test_errors();
    logic [31:0] rsp, exp;
    int e0;
    e0 = err_cnt;
    xfer(mk_frame(2'b00, 1'b0, 4'h0, 4'h0, 16'd500) ^ 32'h1, -1, rsp);
    exp = mk_resp(2'b10, 5'b11000, 16'h0);
    total++; if (rsp !== exp) begin bad++; $display("FAIL badcrc_resp got=%h exp=%h", rsp, exp); end
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL badcrc_err got=%0d exp=%0d", err_cnt, e0 + 1); end
    wait_clk(300);
    total++; if (vout_o[15:0] !== 16'd700) begin bad++; $display("FAIL badcrc_vout got=%0d exp=700", vout_o[15:0]); end
    xfer(mk_frame(2'b00, 1'b0, 4'h0, 4'h5, 16'd123), -1, rsp);
    exp = mk_resp(2'b11, 5'b11000, 16'h0);
    total++; if (rsp !== exp) begin bad++; $display("FAIL sel5_resp got=%h exp=%h", rsp, exp); end
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL sel5_err got=%0d exp=%0d", err_cnt, e0 + 1); end
    xfer(32'h0000_0000, -1, rsp);
    total++; if (err_cnt !== e0 + 2) begin bad++; $display("FAIL badstart_err got=%0d exp=%0d", err_cnt, e0 + 2); end
    wait_clk(300);
    total++; if (vout_o !== {16'd950, 16'd700}) begin bad++; $display("FAIL err_vout got=%h exp=%h", vout_o, {16'd950, 16'd700}); end
  endtask

  task automatic test_broadcast();
    logic [31:0] rsp, exp;
    xfer(mk_frame(2'b00, 1'b0, 4'h0, 4'hF, 16'd1000), -1, rsp);
    exp = mk_resp(2'b00, 5'b11000, 16'h0);
    total++; if (rsp !== exp) begin bad++; $display("FAIL bcast_resp got=%h exp=%h", rsp, exp); end
    wait_clk(6200);
    total++; if (vout_o !== {16'd1000, 16'd1000}) begin bad++; $display("FAIL bcast_vout got=%h exp=%h", vout_o, {16'd1000, 16'd1000}); end
    xfer(mk_frame(2'b11, 1'b0, 4'hE, 4'h0, 16'h0), -1, rsp);
    exp = mk_resp(2'b00, 5'b11000, 16'h0018);
    total++; if (rsp !== exp) begin bad++; $display("FAIL status_resp got=%h exp=%h", rsp, exp); end
    wait_clk(20);
    total++; if (avs_sdata_o !== 1'b1) begin bad++; $display("FAIL status_clr_sdata got=%b exp=1", avs_sdata_o); end
  endtask

  task automatic test_timeout_reset();
    logic [31:0] rsp, exp;
    int e0;
    e0 = err_cnt;
    partial(mk_frame(2'b00, 1'b0, 4'h0, 4'h0, 16'd0), 12);
    wait_clk(5000);
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL timeout_err got=%0d exp=%0d", err_cnt, e0 + 1); end
    total++; if (avs_sdata_o !== 1'b1) begin bad++; $display("FAIL timeout_sdata got=%b exp=1", avs_sdata_o); end
    total++; if (vout_o[15:0] !== 16'd1000) begin bad++; $display("FAIL timeout_vout got=%0d exp=1000", vout_o[15:0]); end
    xfer(mk_frame(2'b11, 1'b0, 4'h0, 4'h0, 16'h0), -1, rsp);
    exp = mk_resp(2'b00, 5'b10000, 16'd1000);
    total++; if (rsp !== exp) begin bad++; $display("FAIL after_to_resp got=%h exp=%h", rsp, exp); end
    e0 = err_cnt;
    xfer(mk_frame(2'b00, 1'b0, 4'h0, 4'h1, 16'd600), 40, rsp);
    wait_clk(10);
    total++; if (vout_o !== {16'd800, 16'd800}) begin bad++; $display("FAIL midrst_vout got=%h exp=%h", vout_o, {16'd800, 16'd800}); end
    total++; if (vdone_o !== 2'b11) begin bad++; $display("FAIL midrst_vdone got=%b exp=11", vdone_o); end
    total++; if (avs_sdata_o !== 1'b1) begin bad++; $display("FAIL midrst_sdata got=%b exp=1", avs_sdata_o); end
    total++; if (err_cnt !== e0) begin bad++; $display("FAIL midrst_err got=%0d exp=%0d", err_cnt, e0); end
    xfer(mk_frame(2'b11, 1'b0, 4'h0, 4'h1, 16'h0), -1, rsp);
    exp = mk_resp(2'b00, 5'b10000, 16'd800);
    total++; if (rsp !== exp) begin bad++; $display("FAIL post_rst_read got=%h exp=%h", rsp, exp); end
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_hold_read();
    test_errors();
    test_broadcast();
    test_timeout_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
